// File: rtl/xup_debounce_pulse_pkg.sv
// xup_debounce_pulse_pkg: shared FSM state codes for the debounce/pulse block
package xup_debounce_pulse_pkg;
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;
endpackage

// File: rtl/xup_debounce_pulse_if.sv
// xup_debounce_pulse_if: raw button in, debounced pulse/level out
interface xup_debounce_pulse_if;
  logic btn_in;
  logic pulse_out;
  logic level_out;
  modport master (output btn_in, input pulse_out, level_out);
  modport slave (input btn_in, output pulse_out, level_out);
endinterface

// File: rtl/xup_sync_2ff.sv
// xup_sync_2ff: two-flop synchroniser for asynchronous inputs, sync active-low reset to 0
module xup_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (!rst_n) {q_o, meta_q} <= 2'b00;
    else {q_o, meta_q} <= {meta_q, d_i};
  end
endmodule

// File: rtl/xup_debounce_pulse.sv
// xup_debounce_pulse: debounces btn_in, gives a held level and a one-clk press pulse
// Optional auto-repeat while held: define XUP_DEBOUNCE_REPEAT_EN.
module xup_debounce_pulse
  import xup_debounce_pulse_pkg::*;
#(
  parameter int DELAY         = 3,
  parameter int STABLE_COUNT  = 500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input logic                 clk,
  input logic                 rst_n,
  xup_debounce_pulse_if.slave bus
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  if (STABLE_COUNT < 2 || REPEAT_PERIOD < 2 || DELAY < 0) begin : g_bad_param
    $error("xup_debounce_pulse: illegal parameter value");
  end
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          s;
`ifdef XUP_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif
  xup_sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (bus.btn_in),
    .q_o  (s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
`ifdef XUP_DEBOUNCE_REPEAT_EN
    rep_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
`ifdef XUP_DEBOUNCE_REPEAT_EN
        else if (rep_q == REP_LAST) pulse_d = 1'b1;
        else rep_d = rep_q + 1'b1;
`endif
      end
      default: begin
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end
`ifdef XUP_DEBOUNCE_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) rep_q <= '0;
    else rep_q <= rep_d;
  end
`endif
  assign bus.pulse_out = pulse_q;
  assign bus.level_out = level_q;
endmodule
